// File: rtl/usb_protocol_ctrl_pkg.sv
// Shared definitions for the USB protocol controller: token/handshake PIDs,
// the transmit request codes and the controller state encoding.
package usb_pkg;

  // PIDs as presented on rx_packet (4-bit PID field).
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  // Largest legal payload held by the data buffer, in bytes.
  localparam logic [6:0] BUF_MAX_BYTES = 7'd64;

  // Requests handed to the transmitter on tx_packet.
  typedef enum logic [3:0] {
    TX_NONE  = 4'd0,
    TX_DATA0 = 4'd1,
    TX_DATA1 = 4'd2,
    TX_ACK   = 4'd3,
    TX_NAK   = 4'd4
  } tx_code_e;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_DATA,
    SEND_ACK,
    SEND_NAK,
    SEND_DATA,
    WAIT_TX_START,
    WAIT_TX_END,
    WAIT_HS,
    ERROR
  } ctrl_state_e;

  // DATA0 and DATA1 differ only in bit 3, which carries the toggle value.
  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

  // True when the transmitter was asked for a data packet (a handshake follows).
  function automatic logic is_data_code(input tx_code_e code);
    return (code == TX_DATA0) || (code == TX_DATA1);
  endfunction

endpackage

// File: rtl/usb_protocol_ctrl_if.sv
// Bus bundle between the protocol controller and its surroundings
// (receiver, transmitter, data buffer, host register block).
// slave  : the controller side.
// master : the environment side that feeds the controller.
interface usb_protocol_ctrl_if;

  logic [3:0] rx_packet;
  logic       rx_data_ready;
  logic       rx_error;
  logic       tx_transfer_active;
  logic       tx_error;
  logic [6:0] buffer_occupancy;
  logic       tx_data_avail;
  logic       host_clear;

  logic [3:0] tx_packet;
  logic       tx_start;
  logic       clear_buffer;
  logic       d_mode;
  logic       rx_data_avail;
  logic       tx_done;
  logic       error_flag;

  modport slave (
    input  rx_packet, rx_data_ready, rx_error, tx_transfer_active, tx_error,
           buffer_occupancy, tx_data_avail, host_clear,
    output tx_packet, tx_start, clear_buffer, d_mode, rx_data_avail, tx_done,
           error_flag
  );

  modport master (
    output rx_packet, rx_data_ready, rx_error, tx_transfer_active, tx_error,
           buffer_occupancy, tx_data_avail, host_clear,
    input  tx_packet, tx_start, clear_buffer, d_mode, rx_data_avail, tx_done,
           error_flag
  );

endinterface

// File: rtl/usb_protocol_ctrl_timer.sv
// Wait-state timeout counter. Held at zero while clear_i is high, counts
// while enable_i is high and flags expiry on the TIMEOUT_CYCLES-th cycle
// of an uninterrupted wait. Only built when USB_CTRL_TIMEOUT_EN is defined.
module usb_ctrl_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  // Count is 0 on the first waiting cycle, so the last cycle is N-1.
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_q;

  // Cycle counter: cleared outside the wait states, saturates at the limit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= 8'd0;
    end else if (clear_i) begin
      count_q <= 8'd0;
    end else if (enable_i && (count_q != LAST_COUNT)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expired_o = enable_i && !clear_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/usb_protocol_ctrl.sv
// USB device-side protocol controller: sequences OUT/DATA/ACK and
// IN/DATA/handshake transactions, tracks the DATA0/DATA1 toggles and
// reports sticky status to the host.
// Optional feature macro: USB_CTRL_TIMEOUT_EN adds a timeout on
// WAIT_DATA / WAIT_HS; without it those states wait indefinitely.
module usb_protocol_ctrl
  import usb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  usb_protocol_ctrl_if.slave bus
);

  ctrl_state_e state_q;
  tx_code_e    tx_packet_q;
  logic        tx_start_q;
  logic        clear_buffer_q;
  logic        d_mode_q;
  logic        rx_data_avail_q;
  logic        tx_done_q;
  logic        error_flag_q;
  logic        rx_toggle_q;
  logic        tx_toggle_q;

  logic        timer_expired;
  logic        active_state;
  logic        wait_data_fault;
  logic        goto_error;

`ifdef USB_CTRL_TIMEOUT_EN
  logic timer_run;

  // The two wait states are never adjacent, so clearing whenever we are
  // outside them guarantees a fresh count on every entry.
  assign timer_run = (state_q == WAIT_DATA) || (state_q == WAIT_HS);

  usb_ctrl_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear_i  (!timer_run),
    .enable_i (timer_run),
    .expired_o(timer_expired)
  );
`else
  assign timer_expired = 1'b0;
`endif

  // Line errors abort any transaction in progress; IDLE ignores them and
  // ERROR is always exactly one cycle long.
  assign active_state = (state_q != IDLE) && (state_q != ERROR);

  assign wait_data_fault = (state_q == WAIT_DATA) &&
                           ((bus.buffer_occupancy > BUF_MAX_BYTES) ||
                            timer_expired ||
                            (bus.rx_data_ready && !is_data_pid(bus.rx_packet)));

  assign goto_error = (active_state && (bus.rx_error || bus.tx_error)) ||
                      wait_data_fault;

  // Transaction FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      tx_packet_q     <= TX_NONE;
      tx_start_q      <= 1'b0;
      clear_buffer_q  <= 1'b0;
      d_mode_q        <= 1'b0;
      rx_data_avail_q <= 1'b0;
      tx_done_q       <= 1'b0;
      error_flag_q    <= 1'b0;
      rx_toggle_q     <= 1'b0;
      tx_toggle_q     <= 1'b0;
    end else begin
      tx_start_q     <= 1'b0;
      clear_buffer_q <= 1'b0;
      tx_done_q      <= 1'b0;

      // Host clear comes first so that a set further down wins.
      if (bus.host_clear) begin
        rx_data_avail_q <= 1'b0;
        error_flag_q    <= 1'b0;
      end

      if (goto_error) begin
        state_q        <= ERROR;
        clear_buffer_q <= 1'b1;
        error_flag_q   <= 1'b1;
        d_mode_q       <= 1'b0;
        tx_packet_q    <= TX_NONE;
      end else begin
        unique case (state_q)
          IDLE: begin
            tx_packet_q <= TX_NONE;
            d_mode_q    <= 1'b0;
            if (bus.rx_data_ready) begin
              if (bus.rx_packet == PID_OUT) begin
                state_q <= WAIT_DATA;
              end else if (bus.rx_packet == PID_IN) begin
                tx_start_q <= 1'b1;
                d_mode_q   <= 1'b1;
                if (bus.tx_data_avail && (bus.buffer_occupancy != 7'd0)) begin
                  state_q     <= SEND_DATA;
                  tx_packet_q <= tx_toggle_q ? TX_DATA1 : TX_DATA0;
                end else begin
                  state_q     <= SEND_NAK;
                  tx_packet_q <= TX_NAK;
                end
              end
            end
          end

          WAIT_DATA: begin
            // Non-DATA PIDs, overflow and timeout are all handled by goto_error.
            if (bus.rx_data_ready) begin
              state_q     <= SEND_ACK;
              tx_start_q  <= 1'b1;
              tx_packet_q <= TX_ACK;
              d_mode_q    <= 1'b1;
              if (bus.rx_packet[3] == rx_toggle_q) begin
                rx_toggle_q     <= ~rx_toggle_q;
                rx_data_avail_q <= 1'b1;
              end else begin
                // Retransmission of a packet we already accepted: ACK it
                // again but drop the duplicate payload.
                clear_buffer_q <= 1'b1;
              end
            end
          end

          SEND_ACK, SEND_NAK, SEND_DATA: begin
            state_q <= WAIT_TX_START;
          end

          WAIT_TX_START: begin
            if (bus.tx_transfer_active) begin
              state_q <= WAIT_TX_END;
            end
          end

          WAIT_TX_END: begin
            if (!bus.tx_transfer_active) begin
              d_mode_q    <= 1'b0;
              tx_packet_q <= TX_NONE;
              state_q     <= is_data_code(tx_packet_q) ? WAIT_HS : IDLE;
            end
          end

          WAIT_HS: begin
            if (timer_expired) begin
              state_q <= IDLE;
            end else if (bus.rx_data_ready) begin
              state_q <= IDLE;
              if (bus.rx_packet == PID_ACK) begin
                tx_toggle_q <= ~tx_toggle_q;
                tx_done_q   <= 1'b1;
              end
            end
          end

          ERROR: begin
            state_q <= IDLE;
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.tx_packet     = tx_packet_q;
  assign bus.tx_start      = tx_start_q;
  assign bus.clear_buffer  = clear_buffer_q;
  assign bus.d_mode        = d_mode_q;
  assign bus.rx_data_avail = rx_data_avail_q;
  assign bus.tx_done       = tx_done_q;
  assign bus.error_flag    = error_flag_q;

endmodule

// File: tb/tb_usb_protocol_ctrl.sv
// Directed testbench for usb_protocol_ctrl. Inputs change 1 ns after the
// rising edge and outputs are checked there, well clear of the next edge.
// With USB_CTRL_TIMEOUT_EN defined the timeout path is exercised;
// otherwise the indefinite wait is checked instead.
module tb_usb_protocol_ctrl;
  import usb_pkg::*;

  logic clk;
  logic n_rst;
  int   checks_cnt;
  int   errors_cnt;

  usb_protocol_ctrl_if bus ();

  usb_protocol_ctrl #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pid(input logic [3:0] pid);
    bus.rx_packet     = pid;
    bus.rx_data_ready = 1'b1;
    tick();
    bus.rx_data_ready = 1'b0;
    $display("txn: pid %b delivered at %0t", pid, $time);
  endtask

  // From a SEND_* state: run the transmitter busy window and land in the
  // following state (IDLE or WAIT_HS).
  task automatic finish_tx();
    tick();
    bus.tx_transfer_active = 1'b1;
    tick();
    bus.tx_transfer_active = 1'b0;
    tick();
  endtask

  task automatic pulse_host_clear();
    bus.host_clear = 1'b1;
    tick();
    bus.host_clear = 1'b0;
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    n_rst = 1'b0;
    bus.rx_packet          = 4'd0;
    bus.rx_data_ready      = 1'b0;
    bus.rx_error           = 1'b0;
    bus.tx_transfer_active = 1'b0;
    bus.tx_error           = 1'b0;
    bus.buffer_occupancy   = 7'd8;
    bus.tx_data_avail      = 1'b1;
    bus.host_clear         = 1'b0;
    repeat (3) tick();
    check_val("rst_tx_packet", 32'(bus.tx_packet), 0);
    check_val("rst_tx_start", 32'(bus.tx_start), 0);
    check_val("rst_d_mode", 32'(bus.d_mode), 0);
    check_val("rst_error_flag", 32'(bus.error_flag), 0);
    n_rst = 1'b1;
    tick();

    // OUT + DATA0 with rx_toggle 0: accepted and ACKed.
    send_pid(PID_OUT);
    check_val("out_wait_no_start", 32'(bus.tx_start), 0);
    send_pid(PID_DATA0);
    check_val("ack_tx_start", 32'(bus.tx_start), 1);
    check_val("ack_tx_packet", 32'(bus.tx_packet), 3);
    check_val("ack_rx_data_avail", 32'(bus.rx_data_avail), 1);
    check_val("ack_no_clear", 32'(bus.clear_buffer), 0);
    check_val("ack_d_mode", 32'(bus.d_mode), 1);
    tick();
    check_val("wts_start_low", 32'(bus.tx_start), 0);
    check_val("wts_packet_held", 32'(bus.tx_packet), 3);
    bus.tx_transfer_active = 1'b1;
    tick();
    check_val("wte_d_mode", 32'(bus.d_mode), 1);
    bus.tx_transfer_active = 1'b0;
    tick();
    check_val("idle_d_mode", 32'(bus.d_mode), 0);
    check_val("idle_packet", 32'(bus.tx_packet), 0);

    // Duplicate DATA0: ACK again, flush buffer, toggle stays 1.
    send_pid(PID_OUT);
    send_pid(PID_DATA0);
    check_val("dup_tx_packet", 32'(bus.tx_packet), 3);
    check_val("dup_clear_buffer", 32'(bus.clear_buffer), 1);
    finish_tx();
    pulse_host_clear();
    check_val("hclr_rx_avail", 32'(bus.rx_data_avail), 0);
    send_pid(PID_OUT);
    send_pid(PID_DATA1);
    check_val("data1_match_no_clear", 32'(bus.clear_buffer), 0);
    check_val("data1_rx_avail", 32'(bus.rx_data_avail), 1);
    finish_tx();

    // IN with payload: DATA0, host ACK flips tx toggle.
    send_pid(PID_IN);
    check_val("in_tx_packet", 32'(bus.tx_packet), 1);
    check_val("in_tx_start", 32'(bus.tx_start), 1);
    check_val("in_d_mode", 32'(bus.d_mode), 1);
    tick();
    bus.tx_transfer_active = 1'b1;
    tick();
    check_val("in_wte_d_mode", 32'(bus.d_mode), 1);
    check_val("in_wte_packet", 32'(bus.tx_packet), 1);
    bus.tx_transfer_active = 1'b0;
    tick();
    check_val("in_whs_d_mode", 32'(bus.d_mode), 0);
    send_pid(PID_ACK);
    check_val("in_tx_done", 32'(bus.tx_done), 1);
    tick();
    check_val("in_tx_done_pulse", 32'(bus.tx_done), 0);

    // Next IN sends DATA1; host NAK keeps the toggle.
    send_pid(PID_IN);
    check_val("in2_tx_packet", 32'(bus.tx_packet), 2);
    finish_tx();
    send_pid(PID_NAK);
    check_val("in2_nak_no_done", 32'(bus.tx_done), 0);
    send_pid(PID_IN);
    check_val("in3_retry_packet", 32'(bus.tx_packet), 2);
    finish_tx();
    send_pid(PID_ACK);
    check_val("in3_tx_done", 32'(bus.tx_done), 1);

    // IN without payload (and with an empty buffer) answers NAK.
    bus.tx_data_avail = 1'b0;
    send_pid(PID_IN);
    check_val("nak_tx_packet", 32'(bus.tx_packet), 4);
    check_val("nak_tx_start", 32'(bus.tx_start), 1);
    finish_tx();
    check_val("nak_idle_packet", 32'(bus.tx_packet), 0);
    send_pid(PID_ACK);
    check_val("nak_then_idle_no_done", 32'(bus.tx_done), 0);
    bus.tx_data_avail    = 1'b1;
    bus.buffer_occupancy = 7'd0;
    send_pid(PID_IN);
    check_val("empty_buf_nak", 32'(bus.tx_packet), 4);
    finish_tx();
    bus.buffer_occupancy = 7'd8;

    // rx_error with DATA0 in WAIT_DATA: error wins.
    send_pid(PID_OUT);
    bus.rx_error = 1'b1;
    send_pid(PID_DATA0);
    bus.rx_error = 1'b0;
    check_val("err_clear_buffer", 32'(bus.clear_buffer), 1);
    check_val("err_flag", 32'(bus.error_flag), 1);
    check_val("err_no_tx_start", 32'(bus.tx_start), 0);
    tick();
    check_val("err_one_cycle", 32'(bus.clear_buffer), 0);
    check_val("err_flag_sticky", 32'(bus.error_flag), 1);
    pulse_host_clear();
    check_val("err_flag_cleared", 32'(bus.error_flag), 0);
    send_pid(PID_OUT);
    send_pid(PID_DATA0);
    check_val("err_toggle_kept", 32'(bus.clear_buffer), 0);
    finish_tx();

    // Buffer occupancy boundary: 64 legal, 65 is an error.
    bus.buffer_occupancy = 7'd64;
    send_pid(PID_OUT);
    tick();
    check_val("occ64_ok", 32'(bus.error_flag), 0);
    bus.buffer_occupancy = 7'd65;
    tick();
    check_val("occ65_error", 32'(bus.error_flag), 1);
    check_val("occ65_clear", 32'(bus.clear_buffer), 1);
    bus.buffer_occupancy = 7'd8;
    tick();
    pulse_host_clear();

    // Wait-state timing.
    send_pid(PID_OUT);
`ifdef USB_CTRL_TIMEOUT_EN
    repeat (15) tick();
    check_val("tmo_not_yet", 32'(bus.clear_buffer), 0);
    tick();
    check_val("tmo_error_cycle16", 32'(bus.clear_buffer), 1);
    check_val("tmo_error_flag", 32'(bus.error_flag), 1);
    tick();
    pulse_host_clear();
`else
    repeat (300) tick();
    check_val("no_tmo_flag", 32'(bus.error_flag), 0);
    send_pid(PID_DATA0);
    check_val("no_tmo_ack", 32'(bus.tx_start), 1);
    check_val("no_tmo_dup_clear", 32'(bus.clear_buffer), 1);
    finish_tx();
`endif

    // rx_error in IDLE is ignored.
    bus.rx_error = 1'b1;
    tick();
    bus.rx_error = 1'b0;
    check_val("idle_rxerr_ignored", 32'(bus.error_flag), 0);

    // Non-DATA PID in WAIT_DATA with simultaneous host_clear: set wins.
    send_pid(PID_OUT);
    bus.host_clear = 1'b1;
    send_pid(PID_ACK);
    bus.host_clear = 1'b0;
    check_val("bad_pid_error", 32'(bus.error_flag), 1);
    tick();
    check_val("set_beats_clear", 32'(bus.error_flag), 1);

    // Reset mid WAIT_TX_END, with tx toggle and rx toggle both at 1.
    send_pid(PID_IN);
    check_val("pre_rst_in_packet", 32'(bus.tx_packet), 1);
    finish_tx();
    send_pid(PID_ACK);
    send_pid(PID_IN);
    check_val("pre_rst_in2_packet", 32'(bus.tx_packet), 2);
    tick();
    bus.tx_transfer_active = 1'b1;
    tick();
    check_val("pre_rst_d_mode", 32'(bus.d_mode), 1);
    #2;
    n_rst = 1'b0;
    #1;
    check_val("midrst_tx_packet", 32'(bus.tx_packet), 0);
    check_val("midrst_d_mode", 32'(bus.d_mode), 0);
    check_val("midrst_error_flag", 32'(bus.error_flag), 0);
    check_val("midrst_tx_start", 32'(bus.tx_start), 0);
    bus.tx_transfer_active = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    send_pid(PID_IN);
    check_val("postrst_tx_toggle0", 32'(bus.tx_packet), 1);
    finish_tx();
    send_pid(PID_NAK);
    send_pid(PID_OUT);
    send_pid(PID_DATA0);
    check_val("postrst_rx_toggle0", 32'(bus.clear_buffer), 0);
    check_val("postrst_rx_avail", 32'(bus.rx_data_avail), 1);
    finish_tx();

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
